// File: rtl/time_pul_generator.sv
// Programmable timing-pulse source: one-cycle CP strobe every N clocks, N picked by a 5-bit switch priority decode.
// Latency: SW -> Sublevel 1 clock; a level change restarts the phase, first CP N_new edges after detection.
// Backpressure: none; free-running strobe, downstream logic samples CP as a clock enable.
module time_pul_generator #(
    parameter int CNT_W = 16,
    parameter int DIV0  = 2,
    parameter int DIV1  = 5,
    parameter int DIV2  = 10,
    parameter int DIV3  = 20,
    parameter int DIV4  = 50,
    parameter int DIV5  = 100
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] SW,
    output logic       CP,
    output logic [3:0] Sublevel
);

    // Terminal counts are N-1, so a divisor of 2^CNT_W still fits the counter.
    localparam logic [CNT_W-1:0] LIM0 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] LIM1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] LIM2 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] LIM3 = CNT_W'(DIV3 - 1);
    localparam logic [CNT_W-1:0] LIM4 = CNT_W'(DIV4 - 1);
    localparam logic [CNT_W-1:0] LIM5 = CNT_W'(DIV5 - 1);

    logic [3:0]       lvl_q, lvl_d, lvl_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d, lim;
    logic             cp_q, cp_d;
    logic             change, at_lim;

    always_comb begin
        lvl_dec = 4'd0;
        priority casez (SW)
            5'b1????: lvl_dec = 4'd5;
            5'b01???: lvl_dec = 4'd4;
            5'b001??: lvl_dec = 4'd3;
            5'b0001?: lvl_dec = 4'd2;
            5'b00001: lvl_dec = 4'd1;
            default:  lvl_dec = 4'd0;
        endcase
    end

    always_comb begin
        lim = LIM0;
        case (lvl_q)
            4'd1:    lim = LIM1;
            4'd2:    lim = LIM2;
            4'd3:    lim = LIM3;
            4'd4:    lim = LIM4;
            4'd5:    lim = LIM5;
            default: lim = LIM0;
        endcase
    end

    always_comb begin
        change = (lvl_dec != lvl_q);
        at_lim = (cnt_q == lim);
        lvl_d  = lvl_dec;
        cnt_d  = cnt_q + CNT_W'(1);
        if (change || at_lim) begin
            cnt_d = '0;
        end
        // No pulse on the detection edge, so a change never truncates or stretches a period.
        cp_d   = !change && at_lim;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lvl_q <= 4'd0;
            cnt_q <= '0;
            cp_q  <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
            cp_q  <= cp_d;
        end
    end

    assign CP       = cp_q;
    assign Sublevel = lvl_q;

endmodule

// File: tb/tb_time_pul_generator.sv
// Bench for time_pul_generator: a default instance and a narrow-counter instance run side by side
// against an edge-index model (pulse whenever the edge distance from the last restart is a multiple of N).
module tb_time_pul_generator;

    logic       CLK;
    logic       RST;
    logic [4:0] SW;
    logic       cp_a, cp_b;
    logic [3:0] sub_a, sub_b;

    int errors = 0;
    int checks = 0;

    int div_a [6] = '{2, 5, 10, 20, 50, 100};
    int div_b [6] = '{3, 5, 10, 12, 15, 16};

    int edge_n = 0;
    int anchor = 0;
    int lvl_m  = 0;
    bit quiet  = 1'b1;

    time_pul_generator dut (
        .CLK(CLK), .RST(RST), .SW(SW), .CP(cp_a), .Sublevel(sub_a)
    );

    time_pul_generator #(
        .CNT_W(4), .DIV0(3), .DIV1(5), .DIV2(10), .DIV3(12), .DIV4(15), .DIV5(16)
    ) dut_n (
        .CLK(CLK), .RST(RST), .SW(SW), .CP(cp_b), .Sublevel(sub_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int decode(input logic [4:0] s);
        for (int i = 4; i >= 0; i--) begin
            if (s[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic step(input int n);
        int dl;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            edge_n++;
            quiet = 1'b0;
            if (RST) begin
                lvl_m  = 0;
                anchor = edge_n;
                quiet  = 1'b1;
            end else begin
                dl = decode(SW);
                if (dl != lvl_m) begin
                    lvl_m  = dl;
                    anchor = edge_n;
                    quiet  = 1'b1;
                end
            end
            #1;
            check("sublevel_a", 32'(sub_a), 32'(lvl_m));
            check("sublevel_b", 32'(sub_b), 32'(lvl_m));
            check("cp_a", 32'(cp_a),
                  32'(!quiet && ((edge_n - anchor) % div_a[lvl_m] == 0)));
            check("cp_b", 32'(cp_b),
                  32'(!quiet && ((edge_n - anchor) % div_b[lvl_m] == 0)));
        end
    endtask

    initial begin
        RST = 1'b1;
        SW  = 5'b00000;
        step(2);
        check("rst_cnt_a", 32'(dut.cnt_q), 32'd0);
        check("rst_cnt_b", 32'(dut_n.cnt_q), 32'd0);
        RST = 1'b0;
        step(30);

        SW = 5'b00010; step(1000);
        SW = 5'b00100; step(1000);
        SW = 5'b01000; step(1000);
        SW = 5'b10000; step(1000);

        SW = 5'b10101; step(250);
        SW = 5'b10000; step(250);
        SW = 5'b00001; step(40);
        SW = 5'b00011; step(7);
        SW = 5'b00010; step(40);

        // Reset 7 clocks into a level-3 period.
        SW = 5'b00100; step(20 + 7);
        RST = 1'b1; step(1);
        check("midrst_cnt_a", 32'(dut.cnt_q), 32'd0);
        check("midrst_cnt_b", 32'(dut_n.cnt_q), 32'd0);
        check("midrst_cp_a", 32'(cp_a), 32'd0);
        RST = 1'b0; step(60);

        for (int seg = 0; seg < 40; seg++) begin
            SW  = 5'($urandom_range(0, 31));
            RST = ($urandom_range(0, 15) == 0);
            step(1);
            RST = 1'b0;
            step($urandom_range(1, 120));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
